// File: rtl/game_countdown_if.sv
`default_nettype none
//============================================================================
// Module      : game_countdown_if
// Description : Control and display bundle of the game round countdown
//               timer. The master side (game FSM) drives the Start, Pause and
//               AddTime controls. The slave side (the timer) returns the BCD
//               digits, the binary seconds value and the status flags.
// Revision    : 1.0 - initial release
//============================================================================
interface game_countdown_if;

    // Control from the game FSM
    logic       Start;
    logic       Pause;
    logic       AddTime;
    logic [3:0] AddAmount;

    // Status and display toward the game FSM and the hex_decoder pair
    logic [3:0] OnesValue;
    logic [3:0] TensValue;
    logic [6:0] SecondsLeft;
    logic       Running;
    logic       Expired;
    logic       TimeUp;
    logic       Warn;

    modport master (
        output Start,
        output Pause,
        output AddTime,
        output AddAmount,
        input  OnesValue,
        input  TensValue,
        input  SecondsLeft,
        input  Running,
        input  Expired,
        input  TimeUp,
        input  Warn
    );

    modport slave (
        input  Start,
        input  Pause,
        input  AddTime,
        input  AddAmount,
        output OnesValue,
        output TensValue,
        output SecondsLeft,
        output Running,
        output Expired,
        output TimeUp,
        output Warn
    );

endinterface
`default_nettype wire

// File: rtl/game_countdown.sv
`default_nettype none
//============================================================================
// Module      : game_countdown
// Description : Two-digit BCD countdown timer for a game round. It loads
//               START_SECONDS on Start and decrements once per
//               CLOCK_FREQUENCY cycles. It can pause while holding the
//               partial second, and it adds saturating bonus time. It raises
//               a one-cycle TimeUp pulse when it reaches 00.
//               Optional feature macro: GAME_COUNTDOWN_WARN_BLINK_EN.
//               When defined, Warn blinks at 1 Hz (high during the first half
//               of each second). When undefined, Warn is steady.
// Revision    : 1.0 - initial release
//============================================================================
module game_countdown #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int START_SECONDS   = 60,
    parameter int WARN_THRESHOLD  = 10
) (
    input  wire             ClockIn,
    input  wire             Reset,
    game_countdown_if.slave bus
);

    // Prescaler width; CLOCK_FREQUENCY is required to be at least 2
    localparam int              c_PW          = $clog2(CLOCK_FREQUENCY);
    localparam logic [c_PW-1:0] c_PRESC_MAX   = c_PW'(CLOCK_FREQUENCY - 1);
    localparam logic [c_PW-1:0] c_PRESC_ONE   = c_PW'(1);
    localparam logic [3:0]      c_START_TENS  = 4'(START_SECONDS / 10);
    localparam logic [3:0]      c_START_ONES  = 4'(START_SECONDS % 10);
    localparam logic            c_START_ZERO  = (START_SECONDS == 0);
    localparam logic [6:0]      c_WARN_LIMIT  = 7'(WARN_THRESHOLD);
    localparam logic [6:0]      c_SAT_MAX     = 7'd99;
    localparam logic [3:0]      c_DIGIT_MAX   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } t_state;

    t_state          r_state;
    t_state          w_state_nxt;
    logic [3:0]      r_ones;
    logic [3:0]      r_tens;
    logic [c_PW-1:0] r_presc;
    logic            r_timeup;

    logic [6:0]      w_secs;
    logic            w_tick;
    logic            w_add;
    logic [3:0]      w_amt;
    logic [6:0]      w_dec;
    logic [7:0]      w_sum;
    logic [6:0]      w_res;
    logic [3:0]      w_res_tens;
    logic [3:0]      w_res_ones;
    logic            w_load;
    logic            w_enter_exp;
    logic            w_active;
    logic            w_warn_base;
    logic            w_warn_phase;

    // Binary view of the registered digits, shared by the arithmetic and the outputs
    assign w_secs = ({3'd0, r_tens} * 7'd10) + {3'd0, r_ones};

    // A tick fires when a second ends in RUNNING. A simultaneous Pause swallows it.
    assign w_tick = (r_state == S_RUNNING) && (r_presc == '0) && !bus.Pause;

    // Bonus time counts only while a round is in progress
    assign w_active = (r_state == S_RUNNING) || (r_state == S_PAUSED);
    assign w_add    = bus.AddTime && w_active;

    // Out-of-range BCD amounts clamp to the largest digit
    assign w_amt = (bus.AddAmount > c_DIGIT_MAX) ? c_DIGIT_MAX : bus.AddAmount;

    // Combined tick and add: decrement first, then add, then saturate at 99
    assign w_dec = w_secs - {6'd0, w_tick};
    assign w_sum = {1'b0, w_dec} + {4'd0, (w_add ? w_amt : 4'd0)};
    assign w_res = (w_sum > {1'b0, c_SAT_MAX}) ? c_SAT_MAX : w_sum[6:0];

    // Split the updated value back into BCD digits
    assign w_res_tens = 4'(w_res / 7'd10);
    assign w_res_ones = 4'(w_res % 7'd10);

    // Next-state logic with the load and expiry events
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_enter_exp = 1'b0;
        case (r_state)
            S_IDLE, S_EXPIRED: begin
                if (bus.Start) begin
                    w_load = 1'b1;
                    if (c_START_ZERO) begin
                        w_state_nxt = S_EXPIRED;
                        w_enter_exp = 1'b1;
                    end else begin
                        w_state_nxt = S_RUNNING;
                    end
                end
            end
            S_RUNNING: begin
                if (w_tick && (w_res == 7'd0)) begin
                    w_state_nxt = S_EXPIRED;
                    w_enter_exp = 1'b1;
                end else if (bus.Pause) begin
                    w_state_nxt = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!bus.Pause) begin
                    w_state_nxt = S_RUNNING;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and the TimeUp flag for the first EXPIRED cycle
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_timeup <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timeup <= w_enter_exp;
        end
    end

    // Per-second prescaler. It holds outside RUNNING so a pause keeps the partial second.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_presc <= c_PRESC_MAX;
        end else if (w_load) begin
            r_presc <= c_PRESC_MAX;
        end else if (r_state == S_RUNNING) begin
            if (r_presc != '0) begin
                r_presc <= r_presc - c_PRESC_ONE;
            end else if (!bus.Pause) begin
                r_presc <= c_PRESC_MAX;
            end
        end
    end

    // BCD digit registers: reload on Start, update on a tick or an accepted add
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_tens <= c_START_TENS;
            r_ones <= c_START_ONES;
        end else if (w_load) begin
            r_tens <= c_START_TENS;
            r_ones <= c_START_ONES;
        end else if (w_tick || w_add) begin
            r_tens <= w_res_tens;
            r_ones <= w_res_ones;
        end
    end

    // Low-time warning, optionally gated by the first half of each second
    assign w_warn_base = w_active && (w_secs != 7'd0) && (w_secs <= c_WARN_LIMIT);

`ifdef GAME_COUNTDOWN_WARN_BLINK_EN
    localparam logic [c_PW-1:0] c_PRESC_HALF = c_PW'(CLOCK_FREQUENCY / 2);
    assign w_warn_phase = (r_presc >= c_PRESC_HALF);
`else
    assign w_warn_phase = 1'b1;
`endif

    assign bus.OnesValue   = r_ones;
    assign bus.TensValue   = r_tens;
    assign bus.SecondsLeft = w_secs;
    assign bus.Running     = (r_state == S_RUNNING);
    assign bus.Expired     = (r_state == S_EXPIRED);
    assign bus.TimeUp      = r_timeup;
    assign bus.Warn        = w_warn_base && w_warn_phase;

endmodule
`default_nettype wire

// File: tb/tb_game_countdown.sv
`timescale 1ns/1ps
module tb_game_countdown;

    localparam int CF = 4;
    localparam int SS = 12;
    localparam int WT = 10;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic ClockIn = 1'b0;
    logic Reset   = 1'b1;

    game_countdown_if bus();

    game_countdown #(
        .CLOCK_FREQUENCY(CF),
        .START_SECONDS  (SS),
        .WARN_THRESHOLD (WT)
    ) dut (
        .ClockIn(ClockIn),
        .Reset  (Reset),
        .bus    (bus)
    );

    always #5 ClockIn = ~ClockIn;

    int errors = 0;
    int checks = 0;

    // Reference model: round mode, seconds left, running cycles spent in the current second
    int m_mode = M_IDLE;
    int m_secs = SS;
    int m_el   = 0;
    bit m_tu   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick;
        bit add;
        int amt;
        int v;
        if (Reset) begin
            m_mode = M_IDLE;
            m_secs = SS;
            m_el   = 0;
            m_tu   = 1'b0;
        end else begin
            m_tu = 1'b0;
            tick = (m_mode == M_RUN) && (m_el == CF - 1) && !bus.Pause;
            add  = bus.AddTime && ((m_mode == M_RUN) || (m_mode == M_PAUSE));
            amt  = (int'(bus.AddAmount) > 9) ? 9 : int'(bus.AddAmount);
            v    = m_secs - (tick ? 1 : 0);
            if (add) v = (v + amt > 99) ? 99 : v + amt;
            case (m_mode)
                M_IDLE, M_EXP: begin
                    if (bus.Start) begin
                        m_secs = SS;
                        m_el   = 0;
                        if (SS == 0) begin
                            m_mode = M_EXP;
                            m_tu   = 1'b1;
                        end else begin
                            m_mode = M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    m_secs = v;
                    if (m_el == CF - 1) begin
                        if (!bus.Pause) m_el = 0;
                    end else begin
                        m_el = m_el + 1;
                    end
                    if (tick && v == 0) begin
                        m_mode = M_EXP;
                        m_tu   = 1'b1;
                    end else if (bus.Pause) begin
                        m_mode = M_PAUSE;
                    end
                end
                default: begin
                    m_secs = v;
                    if (!bus.Pause) m_mode = M_RUN;
                end
            endcase
        end
    endtask

    function automatic int exp_warn();
        bit b;
        b = ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && (m_secs > 0) && (m_secs <= WT);
`ifdef GAME_COUNTDOWN_WARN_BLINK_EN
        b = b && ((CF - 1 - m_el) >= CF / 2);
`endif
        return int'(b);
    endfunction

    task automatic compare_all();
        chk("ones",    int'(bus.OnesValue),   m_secs % 10);
        chk("tens",    int'(bus.TensValue),   m_secs / 10);
        chk("seconds", int'(bus.SecondsLeft), m_secs);
        chk("running", int'(bus.Running),     int'(m_mode == M_RUN));
        chk("expired", int'(bus.Expired),     int'(m_mode == M_EXP));
        chk("timeup",  int'(bus.TimeUp),      int'(m_tu));
        chk("warn",    int'(bus.Warn),        exp_warn());
    endtask

    // One clock: the model takes the same edge as the DUT, outputs are compared 2 ns later
    task automatic step();
        @(posedge ClockIn);
        model_step();
        #2;
        compare_all();
        bus.Start   = 1'b0;
        bus.AddTime = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int tu_cnt;
        bit found;
        bus.Start     = 1'b0;
        bus.Pause     = 1'b0;
        bus.AddTime   = 1'b0;
        bus.AddAmount = 4'd0;

        // Reset state
        Reset = 1'b1;
        steps(2);
        Reset = 1'b0;
        chk("rst_seconds", int'(bus.SecondsLeft), 12);
        chk("rst_running", int'(bus.Running), 0);
        chk("rst_expired", int'(bus.Expired), 0);
        chk("rst_timeup",  int'(bus.TimeUp), 0);
        chk("rst_warn",    int'(bus.Warn), 0);

        // Start, first decrement a full second later
        bus.Start = 1'b1;
        step();
        chk("start_running", int'(bus.Running), 1);
        chk("start_tens",    int'(bus.TensValue), 1);
        chk("start_ones",    int'(bus.OnesValue), 2);
        steps(4);
        chk("sec1_seconds",  int'(bus.SecondsLeft), 11);
        steps(4);
        chk("sec2_tens",     int'(bus.TensValue), 1);
        chk("sec2_ones",     int'(bus.OnesValue), 0);
        chk("sec2_warn",     int'(bus.Warn), 1);

        // Run to expiry, then hold at 00
        tu_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.TimeUp) tu_cnt++;
        end
        chk("timeup_pulses",   tu_cnt, 1);
        chk("exp_seconds",     int'(bus.SecondsLeft), 0);
        chk("exp_expired",     int'(bus.Expired), 1);
        chk("exp_running",     int'(bus.Running), 0);

        // Start from EXPIRED reloads
        bus.Start = 1'b1;
        step();
        chk("restart_seconds", int'(bus.SecondsLeft), 12);
        chk("restart_running", int'(bus.Running), 1);

        // Pause at 05 preserves the partial second; add while paused
        steps(28);
        chk("at05_seconds", int'(bus.SecondsLeft), 5);
        step();
        bus.Pause = 1'b1;
        steps(10);
        chk("paused_seconds", int'(bus.SecondsLeft), 5);
        chk("paused_running", int'(bus.Running), 0);
        bus.AddTime = 1'b1; bus.AddAmount = 4'd9;
        step();
        chk("paused_add",  int'(bus.SecondsLeft), 14);
        chk("paused_warn", int'(bus.Warn), 0);
        bus.Pause = 1'b0;
        steps(2);
        chk("resume_hold", int'(bus.SecondsLeft), 14);
        step();
        chk("resume_tick", int'(bus.SecondsLeft), 13);

        // Climb to 98 while paused, then a tick coincident with +9 saturates
        bus.Pause = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.AddTime = 1'b1; bus.AddAmount = 4'd9;
            step();
        end
        bus.AddTime = 1'b1; bus.AddAmount = 4'd4;
        step();
        chk("at98_seconds", int'(bus.SecondsLeft), 98);
        bus.Pause = 1'b0;
        steps(3);
        bus.AddTime = 1'b1; bus.AddAmount = 4'd9;
        step();
        chk("tick_add_sat", int'(bus.SecondsLeft), 99);
        bus.AddTime = 1'b1; bus.AddAmount = 4'd15;
        step();
        chk("clamp_sat",    int'(bus.SecondsLeft), 99);

        // Count down to 01, then tick coincident with +3
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            step();
            if (bus.SecondsLeft == 7'd1) found = 1'b1;
        end
        chk("reach_01", int'(found), 1);
        steps(3);
        bus.AddTime = 1'b1; bus.AddAmount = 4'd3;
        step();
        chk("rescue_seconds", int'(bus.SecondsLeft), 3);
        chk("rescue_timeup",  int'(bus.TimeUp), 0);
        chk("rescue_running", int'(bus.Running), 1);
        bus.Start = 1'b1;
        step();
        chk("start_ignored",  int'(bus.SecondsLeft), 3);

        // Reset mid-run at 07 overrides a simultaneous Start
        bus.AddTime = 1'b1; bus.AddAmount = 4'd4;
        step();
        chk("at07_seconds", int'(bus.SecondsLeft), 7);
        Reset = 1'b1; bus.Start = 1'b1;
        step();
        Reset = 1'b0;
        chk("midrst_seconds", int'(bus.SecondsLeft), 12);
        chk("midrst_running", int'(bus.Running), 0);
        chk("midrst_expired", int'(bus.Expired), 0);
        chk("midrst_warn",    int'(bus.Warn), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            bus.Start     = ($urandom_range(0, 24) == 0);
            bus.AddTime   = ($urandom_range(0, 9) == 0);
            bus.AddAmount = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) bus.Pause = ~bus.Pause;
            Reset = ($urandom_range(0, 599) == 0);
            step();
        end
        Reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
